// File: rtl/ti_share_pipe_pkg.sv
// Shared defaults and helpers for the TI share pipeline (optional refresh: TI_SHARE_REFRESH_EN).
// share_xor_all() recombines a share vector into its unshared value.
package ti_share_pkg;

   localparam int NSHARES_DEF = 3;
   localparam int SHARE_W_DEF = 4;
   localparam int VEC_W       = NSHARES_DEF * SHARE_W_DEF;

   function automatic logic [SHARE_W_DEF-1:0] share_xor_all(input logic [VEC_W-1:0] vec);
      logic [SHARE_W_DEF-1:0] acc;
      acc = '0;
      for (int i = 0; i < NSHARES_DEF; i++) begin
         acc = acc ^ vec[i*SHARE_W_DEF +: SHARE_W_DEF];
      end
      return acc;
   endfunction

endpackage

// File: rtl/ti_share_pipe_stage.sv
// One elastic pipeline stage: valid flag plus share-vector register, 1 cycle.
// Data loads only on an accepted valid transfer; flush clears valid and leaves data untouched.
module ti_share_stage
   import ti_share_pkg::*;
#(
   parameter int W = VEC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         adv_i,
   input  logic         src_vld_i,
   input  logic [W-1:0] src_dat_i,
   output logic         vld_o,
   output logic [W-1:0] dat_o
);

   logic         vld_d, vld_q;
   logic [W-1:0] dat_q;
   logic         dat_en;

   always_comb begin
      vld_d  = vld_q;
      dat_en = 1'b0;
      if (flush_i) begin
         vld_d = 1'b0;
      end else if (adv_i) begin
         vld_d  = src_vld_i;
         dat_en = src_vld_i;
      end
   end

   // Explicit enable keeps the data flops quiet on bubbles and stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         if (dat_en) begin
            dat_q <= src_dat_i;
         end
      end
   end

   assign vld_o = vld_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/ti_share_pipe.sv
// Elastic TI share-vector pipeline, DEPTH cycles latency, 1/cycle; optional share refresh via TI_SHARE_REFRESH_EN.
// Backpressure: combinational ready chain collapses bubbles; in_ready drops only when every stage is full and stalled.
module ti_share_pipe
   import ti_share_pkg::*;
#(
   parameter  int NSHARES = NSHARES_DEF,
   parameter  int SHARE_W = SHARE_W_DEF,
   parameter  int DEPTH   = 1,
   localparam int W       = NSHARES * SHARE_W,
   localparam int OCC_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [OCC_W-1:0] occupancy
`ifdef TI_SHARE_REFRESH_EN
   ,
   input  logic [(NSHARES-1)*SHARE_W-1:0] rnd
`endif
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] src_vld;
   logic [W-1:0]     d       [DEPTH];
   logic [W-1:0]     src_dat [DEPTH];
   logic [W-1:0]     stage0_dat;

`ifdef TI_SHARE_REFRESH_EN
   logic [SHARE_W-1:0] r_all;
   logic [SHARE_W-1:0] r_cur;

   // Each share is masked separately; the last share absorbs every mask so the recombined value is unchanged.
   always_comb begin
      r_all      = '0;
      r_cur      = '0;
      stage0_dat = in_data;
      for (int i = 0; i < NSHARES - 1; i++) begin
         r_cur = rnd[i*SHARE_W +: SHARE_W];
         stage0_dat[i*SHARE_W +: SHARE_W] = in_data[i*SHARE_W +: SHARE_W] ^ r_cur;
         r_all = r_all ^ r_cur;
      end
      stage0_dat[(NSHARES-1)*SHARE_W +: SHARE_W] =
         in_data[(NSHARES-1)*SHARE_W +: SHARE_W] ^ r_all;
   end
`else
   assign stage0_dat = in_data;
`endif

   // A stage can advance unless it and every stage after it are full while the output stalls.
   always_comb begin
      logic run_full;
      run_full = 1'b1;
      adv      = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         run_full = run_full & v[k];
         adv[k]   = out_ready | ~run_full;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign src_vld[k] = in_valid;
         assign src_dat[k] = stage0_dat;
      end else begin : g_body
         assign src_vld[k] = v[k-1];
         assign src_dat[k] = d[k-1];
      end

      ti_share_stage #(.W(W)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush_i   (flush),
         .adv_i     (adv[k]),
         .src_vld_i (src_vld[k]),
         .src_dat_i (src_dat[k]),
         .vld_o     (v[k]),
         .dat_o     (d[k])
      );
   end

   always_comb begin
      occupancy = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occupancy = occupancy + OCC_W'(v[k]);
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_ti_share_pipe.sv
// Bench for ti_share_pipe at DEPTH=2: directed vector table, corner sequences, and a random run against a queue model.
module tb_ti_share_pipe;
   import ti_share_pkg::*;

   localparam int DEPTH = 2;
   localparam int W     = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    occupancy;
   logic [7:0]    rnd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ti_share_pipe #(.NSHARES(3), .SHARE_W(4), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef TI_SHARE_REFRESH_EN
      ,
      .rnd       (rnd)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // What stage 0 should hold for an accepted word: shares masked by rnd in the refresh build.
   function automatic logic [W-1:0] loaded(input logic [W-1:0] x, input logic [7:0] r);
      logic [W-1:0] y;
      y = x;
`ifdef TI_SHARE_REFRESH_EN
      y[3:0]  = x[3:0]  ^ r[3:0];
      y[7:4]  = x[7:4]  ^ r[7:4];
      y[11:8] = x[11:8] ^ r[3:0] ^ r[7:4];
`else
      if (r == 8'hxx) y = x;
`endif
      return y;
   endfunction

   typedef struct packed {
      logic         iv;
      logic [11:0]  din;
      logic         ordy;
      logic         fl;
      logic         eir;
      logic         eov;
      logic [11:0]  eod;
      logic [1:0]   eocc;
   } vec_t;

   typedef struct packed {
      int          pos;
      logic [11:0] dat;
   } ent_t;

   vec_t tbl [18];
   ent_t q [$];

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // iv din ordy fl | in_ready out_valid out_data occ
      tbl[0]  = '{1'b1, 12'h123, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2'd0};
      tbl[1]  = '{1'b1, 12'hA53, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2'd1};
      tbl[2]  = '{1'b1, 12'h0F0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h123, 2'd2};
      tbl[3]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'hA53, 2'd2};
      tbl[4]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0F0, 2'd1};
      tbl[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2'd0};
      tbl[6]  = '{1'b1, 12'h111, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 2'd0};
      tbl[7]  = '{1'b1, 12'h222, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 2'd1};
      tbl[8]  = '{1'b1, 12'h333, 1'b0, 1'b0, 1'b0, 1'b1, 12'h111, 2'd2};
      tbl[9]  = '{1'b1, 12'h333, 1'b0, 1'b0, 1'b0, 1'b1, 12'h111, 2'd2};
      tbl[10] = '{1'b1, 12'h333, 1'b1, 1'b0, 1'b1, 1'b1, 12'h111, 2'd2};
      tbl[11] = '{1'b1, 12'h444, 1'b1, 1'b0, 1'b1, 1'b1, 12'h222, 2'd2};
      tbl[12] = '{1'b1, 12'h555, 1'b1, 1'b0, 1'b1, 1'b1, 12'h333, 2'd2};
      tbl[13] = '{1'b1, 12'h666, 1'b1, 1'b0, 1'b1, 1'b1, 12'h444, 2'd2};
      tbl[14] = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h555, 2'd2};
      tbl[15] = '{1'b1, 12'h777, 1'b1, 1'b1, 1'b1, 1'b1, 12'h555, 2'd2};
      tbl[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2'd0};
      tbl[17] = '{1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 2'd0};

      // Reset held low with an active, all-ones input.
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 12'hFFF; out_ready = 1'b1; rnd = 8'h00;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("reset_out_valid", 32'(out_valid), 32'd0);
         check("reset_out_data", 32'(out_data), 32'd0);
         check("reset_occupancy", 32'(occupancy), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0;
      rst_n = 1'b1;
      next_cycle();

      // Directed table: streaming, stall/backpressure, full-pipe throughput, flush.
      for (int i = 0; i < 18; i++) begin
         in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].ordy; flush = tbl[i].fl;
         @(negedge clk);
         check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].eir));
         check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
         check($sformatf("tbl%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].eocc));
         if (tbl[i].eov) check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].eod));
         next_cycle();
      end
      flush = 1'b0; in_valid = 1'b0;

`ifdef TI_SHARE_REFRESH_EN
      begin
         bit seen;
         seen = 1'b0;
         in_valid = 1'b1; in_data = 12'h123; rnd = 8'h5A; out_ready = 1'b1;
         next_cycle();
         in_valid = 1'b0; rnd = 8'h00;
         for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
               seen = 1'b1;
               check("refresh_out_data", 32'(out_data), 32'h0E79);
               check("refresh_recombined", 32'(share_xor_all(out_data)), 32'(4'h3 ^ 4'h2 ^ 4'h1));
            end
            next_cycle();
         end
         check("refresh_seen", 32'(seen), 32'd1);
      end
`endif

      // Random traffic against a queue model: items slide forward until they hit the next item or the output.
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic iv, ordy, fl, eir, eov;
         logic [W-1:0] din;
         logic [7:0]   r;
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 24) == 0);
         din  = W'($urandom);
         r    = 8'($urandom);
         in_valid = iv; out_ready = ordy; flush = fl; in_data = din; rnd = r;
         @(negedge clk);
         eir = !(q.size() == DEPTH && !ordy);
         eov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
         check("rand_in_ready", 32'(in_ready), 32'(eir));
         check("rand_out_valid", 32'(out_valid), 32'(eov));
         check("rand_occupancy", 32'(occupancy), 32'(q.size()));
         if (eov) check("rand_out_data", 32'(out_data), 32'(q[0].dat));
         if (fl) begin
            q.delete();
         end else begin
            if (ordy && eov) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
               int lim;
               ent_t e;
               lim = (i == 0) ? DEPTH - 1 : q[i-1].pos - 1;
               e = q[i];
               if (e.pos < lim) e.pos = e.pos + 1;
               q[i] = e;
            end
            if (iv && eir) q.push_back('{0, loaded(din, r)});
         end
         next_cycle();
      end

      // Mid-stream reset: fill, then drop rst_n between edges.
      flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 12'hABC;
      next_cycle();
      next_cycle();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_occupancy", 32'(occupancy), 32'd0);
      check("midreset_out_data", 32'(out_data), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset_in_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
